// File: rtl/led_blink_sched.sv
// Round-robin arbiter that shares one LED between several requesters. Each granted
// blink code plays as N on/off phase pairs, followed by an optional dark gap.
module led_blink_sched #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int PHASE_CYCLES = CLK_FREQ / 2,
  parameter int GAP_PHASES   = 2,
  parameter int NUM_REQ      = 4,
  parameter int CNT_W        = 4,
  localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*CNT_W-1:0] req_count,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     busy,
  output logic [ID_W-1:0]          grant_id,
  output logic                     led
);

  localparam int PH_W    = $clog2(PHASE_CYCLES + 1);
  localparam int GAP_TOT = GAP_PHASES * PHASE_CYCLES;
  localparam int GAP_W   = (GAP_TOT > 1) ? $clog2(GAP_TOT) : 1;
  localparam logic [PH_W-1:0]  PH_LOAD  = PH_W'(PHASE_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_TOT > 0) ? GAP_W'(GAP_TOT - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [CNT_W-1:0]  blink_q, blink_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;

  logic              found;
  logic [ID_W-1:0]   winner;
  logic [CNT_W-1:0]  sel_count;
  logic              accept;

  // Round-robin search starts at rr_ptr and wraps modulo NUM_REQ.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[ID_W'(idx)]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  always_comb begin
    sel_count = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ID_W'(k) == winner) sel_count = req_count[k*CNT_W +: CNT_W];
    end
  end

  // Valid/ready: a requester holds valid and its count stable until it sees ready;
  // the transfer happens on the clock edge where both are high. Ready is offered
  // only in IDLE, one-hot on the winner, and never while rst is high.
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && found && !rst) req_ready[winner] = 1'b1;
  end

  assign accept = (state_q == S_IDLE) && found && !rst;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    gap_d      = gap_q;
    blink_d    = blink_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          grant_id_d = winner;
          rr_ptr_d   = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
          blink_d    = sel_count;
          phase_d    = PH_LOAD;
          // A zero count is consumed without playing anything.
          if (sel_count != '0) state_d = S_ON;
        end
      end
      S_ON: begin
        if (phase_q == '0) begin
          phase_d = PH_LOAD;
          state_d = S_OFF;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      S_OFF: begin
        if (phase_q == '0) begin
          phase_d = PH_LOAD;
          blink_d = blink_q - 1'b1;
          if (blink_q == CNT_W'(1)) begin
            if (GAP_PHASES == 0) begin
              state_d = S_IDLE;
            end else begin
              gap_d   = GAP_LOAD;
              state_d = S_GAP;
            end
          end else begin
            state_d = S_ON;
          end
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      gap_q      <= '0;
      blink_q    <= '0;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      gap_q      <= gap_d;
      blink_q    <= blink_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign led      = (state_q == S_ON);
  assign busy     = (state_q != S_IDLE);
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_led_blink_sched.sv
// Bench for led_blink_sched: instance A (4-cycle phases, 2-phase gap) and instance B
// (1-cycle phases, no gap); handshakes are checked against expected grant queues.
module tb_led_blink_sched;

  logic        clk;
  logic        rst_a, rst_b;
  logic [3:0]  a_valid, a_ready, b_valid, b_ready;
  logic [15:0] a_count, b_count;
  logic        a_busy, a_led, b_busy, b_led;
  logic [1:0]  a_gid, b_gid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [1:0] exp_qa[$];
  logic [1:0] exp_qb[$];
  logic       pend_a = 1'b0, pend_b = 1'b0;
  logic [1:0] pend_id_a, pend_id_b, e_a, e_b;

  led_blink_sched #(.PHASE_CYCLES(4), .GAP_PHASES(2), .NUM_REQ(4), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst_a), .req_valid(a_valid), .req_count(a_count),
    .req_ready(a_ready), .busy(a_busy), .grant_id(a_gid), .led(a_led)
  );

  led_blink_sched #(.PHASE_CYCLES(1), .GAP_PHASES(0), .NUM_REQ(4), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst_b), .req_valid(b_valid), .req_count(b_count),
    .req_ready(b_ready), .busy(b_busy), .grant_id(b_gid), .led(b_led)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitors: pop on every handshake, then check grant_id one cycle later
  always @(negedge clk) begin
    if (pend_a) begin
      chk("grant_id_a", 32'(a_gid), 32'(pend_id_a));
      pend_a = 1'b0;
    end
    if ((a_valid & a_ready) != 4'b0) begin
      if (exp_qa.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_grant_a: got %b expected none", a_valid & a_ready);
      end else begin
        e_a = exp_qa.pop_front();
        chk("accept_a", 32'(a_valid & a_ready), 32'(4'b0001 << e_a));
        pend_a = 1'b1;
        pend_id_a = e_a;
      end
    end
  end

  always @(negedge clk) begin
    if (pend_b) begin
      chk("grant_id_b", 32'(b_gid), 32'(pend_id_b));
      pend_b = 1'b0;
    end
    if ((b_valid & b_ready) != 4'b0) begin
      if (exp_qb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_grant_b: got %b expected none", b_valid & b_ready);
      end else begin
        e_b = exp_qb.pop_front();
        chk("accept_b", 32'(b_valid & b_ready), 32'(4'b0001 << e_b));
        pend_b = 1'b1;
        pend_id_b = e_b;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input bit sel_b, input int max_cyc, output int at);
    at = -1;
    for (int i = 0; i < max_cyc && at < 0; i++) begin
      @(negedge clk);
      if (sel_b ? ((b_valid & b_ready) != 4'b0) : ((a_valid & a_ready) != 4'b0)) at = cyc;
    end
    tick();
    if (at < 0) begin
      total++; bad++;
      $display("FAIL hs_timeout: got no handshake expected one within %0d cycles", max_cyc);
    end
  endtask

  task automatic wait_idle(input bit sel_b, input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (!(sel_b ? b_busy : a_busy)) seen = 1'b1;
    end
    tick();
    if (!seen) begin
      total++; bad++;
      $display("FAIL idle_timeout: got busy expected idle within %0d cycles", max_cyc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected test end");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int  t, t1, t2, prev, npulse;
    logic exp_led;

    rst_a = 1'b1; rst_b = 1'b1;
    a_valid = 4'hF; b_valid = 4'hF;
    a_count = 16'h1111; b_count = 16'h1111;

    // reset with all requests pending
    repeat (3) begin
      @(negedge clk);
      chk("rst_led", 32'(a_led), 0);
      chk("rst_busy", 32'(a_busy), 0);
      chk("rst_ready", 32'(a_ready), 0);
      chk("rst_gid", 32'(a_gid), 0);
      chk("rst_ready_b", 32'(b_ready), 0);
    end
    tick();
    a_valid = 4'b0; b_valid = 4'b0;
    rst_a = 1'b0; rst_b = 1'b0;
    tick();

    // single code: req 2, count 3; req 3 waits while busy
    a_count = 16'h1300;
    exp_qa.push_back(2'd2);
    a_valid = 4'b0100;
    wait_hs(1'b0, 10, t);
    a_valid = 4'b1000;
    exp_qa.push_back(2'd3);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      exp_led = (k >= 1 && k <= 4) || (k >= 9 && k <= 12) || (k >= 17 && k <= 20);
      chk("single_led", 32'(a_led), 32'(exp_led));
      chk("single_busy", 32'(a_busy), 1);
      chk("single_ready_busy", 32'(a_ready), 0);
      tick();
    end
    @(negedge clk);
    chk("single_busy_end", 32'(a_busy), 0);
    chk("single_next_ready", 32'(a_ready), 32'(4'b1000));
    tick();
    a_valid = 4'b0;
    wait_idle(1'b0, 40);

    // round robin: all valid, count 1 each, rr_ptr starts at 0
    a_count = 16'h1111;
    a_valid = 4'hF;
    exp_qa.push_back(2'd0); exp_qa.push_back(2'd1); exp_qa.push_back(2'd2);
    exp_qa.push_back(2'd3); exp_qa.push_back(2'd0);
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      wait_hs(1'b0, 40, t);
      if (n > 0) chk("rr_spacing", 32'(t - prev), 17);
      prev = t;
    end
    a_valid = 4'b0;
    wait_idle(1'b0, 40);

    // zero count on req 1: no play, pointer moves to 2 so req 3 beats req 0
    a_count = 16'h1001;
    a_valid = 4'b0010;
    exp_qa.push_back(2'd1);
    wait_hs(1'b0, 10, t);
    a_valid = 4'b0;
    @(negedge clk);
    chk("zero_busy", 32'(a_busy), 0);
    chk("zero_led", 32'(a_led), 0);
    chk("zero_ready", 32'(a_ready), 0);
    tick();
    a_valid = 4'b1001;
    exp_qa.push_back(2'd3);
    exp_qa.push_back(2'd0);
    wait_hs(1'b0, 10, t1);
    wait_hs(1'b0, 40, t2);
    chk("zero_regrant", 32'(t1 - t), 2);
    chk("zero_spacing", 32'(t2 - t1), 17);
    a_valid = 4'b0;
    wait_idle(1'b0, 40);

    // reset during second ON phase of a count-5 code
    a_count = 16'h0025;
    a_valid = 4'b0001;
    exp_qa.push_back(2'd0);
    wait_hs(1'b0, 10, t);
    a_valid = 4'b0011;
    repeat (9) tick();
    @(negedge clk);
    chk("mid_led_on", 32'(a_led), 1);
    rst_a = 1'b1;
    @(negedge clk);
    chk("mid_rst_led", 32'(a_led), 0);
    chk("mid_rst_busy", 32'(a_busy), 0);
    chk("mid_rst_ready", 32'(a_ready), 0);
    chk("mid_rst_gid", 32'(a_gid), 0);
    tick();
    rst_a = 1'b0;
    exp_qa.push_back(2'd0);
    wait_hs(1'b0, 5, t);
    a_valid = 4'b0;
    wait_idle(1'b0, 80);

    // valid withdrawn while busy: req 2 must never be granted
    a_count = 16'h0101;
    a_valid = 4'b0001;
    exp_qa.push_back(2'd0);
    wait_hs(1'b0, 10, t);
    a_valid = 4'b0100;
    repeat (5) begin
      @(negedge clk);
      chk("withdraw_ready_busy", 32'(a_ready), 0);
      tick();
    end
    a_valid = 4'b0;
    wait_idle(1'b0, 40);
    repeat (4) begin
      @(negedge clk);
      chk("withdraw_no_ready", 32'(a_ready), 0);
      tick();
    end

    // max count 15 with single-cycle phases and no gap, then immediate re-grant
    b_count = 16'h01F0;
    b_valid = 4'b0010;
    exp_qb.push_back(2'd1);
    wait_hs(1'b1, 10, t);
    b_valid = 4'b0100;
    exp_qb.push_back(2'd2);
    npulse = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      chk("max_led", 32'(b_led), 32'(k % 2));
      chk("max_busy", 32'(b_busy), 1);
      if (b_led) npulse++;
      tick();
    end
    chk("max_pulses", 32'(npulse), 15);
    @(negedge clk);
    chk("max_busy_end", 32'(b_busy), 0);
    chk("max_regrant", 32'(b_ready), 32'(4'b0100));
    tick();
    b_valid = 4'b0;
    @(negedge clk);
    chk("max_next_on", 32'(b_led), 1);
    tick();
    wait_idle(1'b1, 10);

    repeat (2) tick();
    chk("queue_a_empty", 32'(exp_qa.size()), 0);
    chk("queue_b_empty", 32'(exp_qb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_blink_sched.md
Name: led_blink_sched

Overview:
- Round-robin scheduler that shares the single board LED between NUM_REQ requesters.
- Each requester submits a blink code (number of blinks). The block grants one requester at a time, then drives the LED through N on/off phases followed by an inter-code gap.
- Sits between status/fault sources and the LED pin, replacing a free-running blinker when several sources need to report codes.

Parameters:
- CLK_FREQ, 100_000_000, clock frequency in Hz; used only to derive the PHASE_CYCLES default.
- PHASE_CYCLES, CLK_FREQ/2, length of each on phase and each off phase, in clk cycles; must be >= 1.
- GAP_PHASES, 2, length of the post-code gap, in units of PHASE_CYCLES; 0 allowed (no gap).
- NUM_REQ, 4, number of requesters; >= 1.
- CNT_W, 4, width of each blink-count field.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; one clock, reset is synchronous and active-high.
- req_valid  input  NUM_REQ  bit i high: requester i has a code pending.
- req_count  input  NUM_REQ*CNT_W  blink count of requester i in bits [i*CNT_W +: CNT_W]; held stable while valid.
- req_ready  output  NUM_REQ  one-hot accept; handshake for i completes on the edge where valid[i] and ready[i] are both high.
- busy  output  1  high while a code or gap is being played.
- grant_id  output  max(1,$clog2(NUM_REQ))  index of the last accepted requester.
- led  output  1  LED drive, high = on.

Behaviour:
Reset:
- rst sampled high sets state=IDLE, led=0, busy=0, grant_id=0, rr_ptr=0, phase and blink counters=0.
- Reset mid-code aborts the code immediately; the LED is off on the cycle after the reset edge.
- req_ready=0 while rst is high.

States: IDLE, ON, OFF, GAP.

Arbitration (IDLE only, combinational):
- Winner = first i with req_valid[i] set, searching from rr_ptr upward and wrapping mod NUM_REQ.
- req_ready is one-hot on the winner and 0 when no request is valid.
- req_ready=0 in every state other than IDLE.
- Valid may drop without acceptance; there is no obligation to complete.

Accept edge (handshake true):
- grant_id <= winner; rr_ptr <= (winner+1) mod NUM_REQ.
- blink_cnt <= req_count[winner]; phase counter reloads to PHASE_CYCLES-1.
- Count != 0: state -> ON; led=1 and busy=1 from the next cycle.
- Count == 0: no blink and no gap; state stays IDLE, busy stays 0, rr_ptr still advances.

ON:
- led=1 for exactly PHASE_CYCLES cycles, then -> OFF.

OFF:
- led=0 for PHASE_CYCLES cycles; blink_cnt decrements at the end of the phase.
- If blink_cnt was 1: -> GAP, or -> IDLE if GAP_PHASES==0. Otherwise -> ON.

GAP:
- led=0 for GAP_PHASES*PHASE_CYCLES cycles, then -> IDLE.

Busy and throughput:
- busy=1 in ON, OFF and GAP.
- A code of N occupies exactly (2N+GAP_PHASES)*PHASE_CYCLES cycles from the cycle after accept.
- IDLE offers a grant on its first cycle, so back-to-back codes cost 1 IDLE cycle between them.

Counter widths and ranges:
- Phase counter width = $clog2(PHASE_CYCLES+1).
- Gap counter spans GAP_PHASES*PHASE_CYCLES with no overflow.
- The maximum count 2^CNT_W-1 must play fully (15 blinks at defaults).

Concurrency:
- Requests arriving while busy wait; they are not queued internally.
- Simultaneous requests are served in round-robin order; no requester is starved.
- NUM_REQ=1: grant is always requester 0.

Test Plan:
- Reset: rst high for 3 cycles with req_valid=4'b1111 -> led=0, busy=0, req_ready=0, grant_id=0 throughout.
- Single code (PHASE_CYCLES=4, GAP_PHASES=2): req 2 with count=3 accepted at cycle T:
  - led high on T+1..T+4, T+9..T+12, T+17..T+20; low otherwise.
  - busy high T+1..T+32; grant_id=2; next req_ready at T+33.
- Round robin: all four valid, each count=1 -> accept order 0,1,2,3,0. Each accept is spaced 17 cycles after the previous (16 busy + 1 IDLE).
- Zero count: req 1 with count=0 -> ready for one cycle; led and busy stay 0; next winner search starts at 2. With req 0 and req 3 valid, req 3 is granted first.
- Reset mid-code: assert rst during the second ON phase of count=5 -> led=0 next cycle, state IDLE. After rst drops with req 0 valid, req 0 is granted (rr_ptr=0).
- Boundaries:
  - count=15 with PHASE_CYCLES=1, GAP_PHASES=0 -> exactly 15 single-cycle pulses, busy 30 cycles, then immediate re-grant.
  - Valid withdrawn while busy -> no grant to that requester.
